// File: rtl/pooled_flatten_buffer.sv
// Ping-pong frame buffer that collects pooled feature-map pixels in kernel-major order
// and streams each completed frame out over a ready/valid handshake.
module pooled_flatten_buffer #(
  parameter int BitSize            = 32,
  parameter int NumberOfK          = 4,
  parameter int ProcessingElements = 2,
  parameter int ImageWidth         = 2
) (
  input  logic                                            clk,
  input  logic                                            res_n,
  input  logic [NumberOfK-1:0]                            in_valid,
  input  logic [ProcessingElements*BitSize-1:0]           in_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [BitSize-1:0]                              out_data,
  output logic [$clog2(NumberOfK*ImageWidth*ImageWidth)-1:0] out_index,
  output logic                                            out_last,
  output logic                                            err
);

  localparam int P     = ImageWidth * ImageWidth;
  localparam int Words = NumberOfK * P;
  localparam int IW    = $clog2(Words);
  localparam int PW    = IW + 1;
  localparam int CW    = $clog2(P + 1);
  localparam int LW    = (ProcessingElements > 1) ? $clog2(ProcessingElements) : 1;
  localparam int LCW   = LW + 1;

  logic [BitSize-1:0] mem_r [2][Words];
  logic [CW-1:0]      cnt_r [NumberOfK];
  logic [CW-1:0]      cnt_nxt_s [NumberOfK];
  logic [LW-1:0]      lane_s [NumberOfK];
  logic [IW-1:0]      addr_s [NumberOfK];
  logic [BitSize-1:0] sample_s [NumberOfK];
  logic [NumberOfK-1:0] take_s;
  logic [NumberOfK-1:0] wr_en_s;
  logic [NumberOfK-1:0] drop_s;
  logic [LCW-1:0]     lane_cnt_s;
  logic               overflow_s;
  logic               close_s;
  logic               err_set_s;
  logic [1:0]         full_r;
  logic               wb_r;
  logic               rb_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [PW-1:0]      rd_ptr_s;
  logic               rd_bank_s;
  logic               release_s;
  logic               load_s;

  // Lane assignment, write enables and frame-close detection for the capture side.
  always_comb begin
    lane_cnt_s = {LCW{1'b0}};
    overflow_s = 1'b0;
    close_s    = 1'b1;
    for (int k = 0; k < NumberOfK; k++) begin
      take_s[k] = 1'b0;
      lane_s[k] = {LW{1'b0}};
      if (in_valid[k]) begin
        if (lane_cnt_s < LCW'(ProcessingElements)) begin
          take_s[k]  = 1'b1;
          lane_s[k]  = lane_cnt_s[LW-1:0];
          lane_cnt_s = lane_cnt_s + LCW'(1);
        end else begin
          overflow_s = 1'b1;
        end
      end else begin
        take_s[k] = 1'b0;
      end
      // A kernel already holding P pixels, or a fully occupied buffer, drops the sample.
      wr_en_s[k]   = take_s[k] & ~full_r[wb_r] & (cnt_r[k] != CW'(P));
      drop_s[k]    = take_s[k] & ~wr_en_s[k];
      cnt_nxt_s[k] = cnt_r[k] + CW'(wr_en_s[k]);
      addr_s[k]    = IW'(k * P) + IW'(cnt_r[k]);
      sample_s[k]  = in_data[int'(lane_s[k]) * BitSize +: BitSize];
      if (cnt_nxt_s[k] != CW'(P)) begin
        close_s = 1'b0;
      end else begin
        close_s = close_s;
      end
    end
    err_set_s = overflow_s | (|drop_s);
  end

  // Read side: on last-word release, look ahead into the other bank so frames stream gap-free.
  always_comb begin
    release_s = out_valid & out_ready & out_last;
    if (release_s) begin
      rd_bank_s = ~rb_r;
      rd_ptr_s  = {PW{1'b0}};
    end else begin
      rd_bank_s = rb_r;
      rd_ptr_s  = rd_ptr_r;
    end
    load_s = full_r[rd_bank_s] & (rd_ptr_s < PW'(Words)) & (~out_valid | out_ready);
  end

  // Control state, bank flags and the registered output stage.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      full_r    <= 2'b00;
      wb_r      <= 1'b0;
      rb_r      <= 1'b0;
      rd_ptr_r  <= {PW{1'b0}};
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {BitSize{1'b0}};
      out_index <= {IW{1'b0}};
      out_last  <= 1'b0;
      for (int k = 0; k < NumberOfK; k++) begin
        cnt_r[k] <= {CW{1'b0}};
      end
    end else begin
      err <= err | err_set_s;
      for (int k = 0; k < NumberOfK; k++) begin
        cnt_r[k] <= close_s ? {CW{1'b0}} : cnt_nxt_s[k];
      end
      if (close_s) begin
        wb_r <= ~wb_r;
      end
      for (int b = 0; b < 2; b++) begin
        full_r[b] <= (full_r[b] & ~(release_s & (rb_r == 1'(b))))
                   | (close_s & (wb_r == 1'(b)));
      end
      rb_r <= rd_bank_s;
      if (load_s) begin
        out_valid <= 1'b1;
        out_data  <= mem_r[rd_bank_s][rd_ptr_s[IW-1:0]];
        out_index <= rd_ptr_s[IW-1:0];
        out_last  <= (rd_ptr_s == PW'(Words - 1));
        rd_ptr_r  <= rd_ptr_s + PW'(1);
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
        rd_ptr_r  <= rd_ptr_s;
      end else begin
        rd_ptr_r  <= rd_ptr_s;
      end
    end
  end

  // Storage banks; contents need no reset because the full flags gate every read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NumberOfK; k++) begin
      if (wr_en_s[k]) begin
        mem_r[wb_r][addr_s[k]] <= sample_s[k];
      end
    end
  end

endmodule

// File: tb/tb_pooled_flatten_buffer.sv
// Self-checking bench for pooled_flatten_buffer: directed scenarios plus a random phase,
// all outputs compared against a frame-level scoreboard model.
module tb_pooled_flatten_buffer;

  localparam int BS = 32;
  localparam int K  = 4;
  localparam int PE = 2;
  localparam int IW = 2;
  localparam int P  = IW * IW;
  localparam int W  = K * P;

  logic            clk = 1'b0;
  logic            res_n = 1'b0;
  logic [K-1:0]    in_valid = '0;
  logic [PE*BS-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BS-1:0]   out_data;
  logic [3:0]      out_index;
  logic            out_last;
  logic            err;

  always #5 clk = ~clk;

  pooled_flatten_buffer #(
    .BitSize(BS), .NumberOfK(K), .ProcessingElements(PE), .ImageWidth(IW)
  ) dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .err(err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-kernel pixel lists, count of stored frames, queue of expected words.
  typedef struct {
    logic [31:0] d;
    int          idx;
  } word_t;

  int          m_cnt [K];
  int          m_stored;
  logic        m_err;
  logic [31:0] m_frame [W];
  word_t       exp_q [$];
  int          acc_cnt;

  task automatic model_reset();
    for (int k = 0; k < K; k++) m_cnt[k] = 0;
    m_stored = 0;
    m_err    = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_input(input logic [K-1:0] v, input logic [PE*BS-1:0] d);
    int lane;
    bit done;
    lane = 0;
    for (int k = 0; k < K; k++) begin
      if (v[k]) begin
        if (lane >= PE) begin
          m_err = 1'b1;
        end else begin
          if (m_stored == 2 || m_cnt[k] == P) begin
            m_err = 1'b1;
          end else begin
            m_frame[k*P + m_cnt[k]] = d[lane*BS +: BS];
            m_cnt[k]++;
          end
          lane++;
        end
      end
    end
    done = 1'b1;
    for (int k = 0; k < K; k++) if (m_cnt[k] != P) done = 1'b0;
    if (done) begin
      for (int i = 0; i < W; i++) exp_q.push_back('{d: m_frame[i], idx: i});
      m_stored++;
      for (int k = 0; k < K; k++) m_cnt[k] = 0;
    end
  endtask

  // One cycle: sample outputs at the falling edge, check, then drive inputs for the next edge.
  task automatic step(input logic [K-1:0] v, input logic [PE*BS-1:0] d, input logic rdy);
    bit had;
    @(negedge clk);
    check_val("err", err, m_err);
    if (out_valid) begin
      check_val("valid_has_word", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check_val("out_data", out_data, exp_q[0].d);
        check_val("out_index", out_index, exp_q[0].idx);
        check_val("out_last", out_last, exp_q[0].idx == W - 1);
      end
    end
    had       = out_valid && (exp_q.size() != 0);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    model_input(v, d);
    if (had && rdy) begin
      if (exp_q[0].idx == W - 1) m_stored--;
      void'(exp_q.pop_front());
      acc_cnt++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, out_valid, 0);
    check_val({tag, "_data"}, out_data, 0);
    check_val({tag, "_index"}, out_index, 0);
    check_val({tag, "_last"}, out_last, 0);
    check_val({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    model_reset();
    @(negedge clk);
    res_n = 1'b1;
  endtask

  task automatic send_frame(input int base, input logic rdy);
    for (int p = 0; p < P; p++) step(4'b0011, {32'(base + 10 + p), 32'(base + p)}, rdy);
    for (int p = 0; p < P; p++) step(4'b1100, {32'(base + 30 + p), 32'(base + 20 + p)}, rdy);
  endtask

  task automatic drain(input int mode);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      step('0, '0, (mode == 1) ? i[0] : 1'b1);
    end
    check_val("drained", exp_q.size(), 0);
    step('0, '0, 1'b1);
    check_val("idle_after_drain", out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    model_reset();
    acc_cnt = 0;

    // Basic frame, latency and ordering
    do_reset();
    acc_cnt = 0;
    send_frame(0, 1'b1);
    step('0, '0, 1'b1);
    check_val("lat_pre", out_valid, 0);
    step('0, '0, 1'b1);
    check_val("lat_rise", out_valid, 1);
    drain(0);
    check_val("t1_words", acc_cnt, 16);

    // Toggling ready
    acc_cnt = 0;
    send_frame(0, 1'b1);
    drain(1);
    check_val("t2_words", acc_cnt, 16);

    // Three frames, third dropped, gap-free drain of two
    acc_cnt = 0;
    send_frame(100, 1'b0);
    send_frame(200, 1'b0);
    send_frame(300, 1'b0);
    step('0, '0, 1'b0);
    check_val("t3_err", err, 1);
    a = acc_cnt;
    repeat (32) step('0, '0, 1'b1);
    check_val("b2b_words", acc_cnt - a, 32);
    step('0, '0, 1'b1);
    check_val("t3_idle", out_valid, 0);
    check_val("t3_err_sticky", err, 1);

    // Lane overflow
    do_reset();
    step(4'b0111, {32'h0000_000B, 32'h0000_000A}, 1'b1);
    step('0, '0, 1'b1);
    check_val("t4_err", err, 1);
    for (int p = 1; p < P; p++) step(4'b0011, {32'(40 + p), 32'(50 + p)}, 1'b1);
    for (int p = 0; p < P; p++) step(4'b1100, {32'(60 + p), 32'(70 + p)}, 1'b1);
    drain(0);

    // Extra pixel on a completed kernel
    do_reset();
    for (int p = 0; p < 5; p++) step(4'b0001, {32'h0, 32'(500 + p)}, 1'b1);
    for (int p = 0; p < P; p++) step(4'b0010, {32'h0, 32'(510 + p)}, 1'b1);
    for (int p = 0; p < P; p++) step(4'b1100, {32'(530 + p), 32'(520 + p)}, 1'b1);
    check_val("t5_err", err, 1);
    drain(0);

    // Reset in the middle of a drain
    do_reset();
    acc_cnt = 0;
    send_frame(600, 1'b1);
    step(4'b1111, {32'h77, 32'h66}, 1'b1);
    for (int i = 0; i < 100 && acc_cnt < 7; i++) step('0, '0, 1'b1);
    check_val("t6_reached", acc_cnt, 7);
    #2 res_n = 1'b0;
    #1 check_reset_outputs("mid_drain");
    model_reset();
    @(negedge clk);
    res_n = 1'b1;
    acc_cnt = 0;
    send_frame(700, 1'b1);
    drain(0);
    check_val("t6_words", acc_cnt, 16);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom & $urandom), {$urandom, $urandom}, ($urandom % 4) != 0);
    end
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
